// File: rtl/fir_coef_bank_if.sv
// Stream, read and status signals between the folding controller / loader
// and the double-buffered FIR coefficient store.
interface fir_coef_bank_if #(
  parameter int COEF_W = 10,
  parameter int CNT_W  = 6
);
  logic [CNT_W-1:0]  cnt;
  logic              rd_en;
  logic [COEF_W-1:0] coefficient;
  logic              coef_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [COEF_W-1:0] wr_data;
  logic              wr_last;
  logic              swap_req;
  logic              active_bank;
  logic              load_err;

  modport slave (
    input  cnt, rd_en, wr_valid, wr_data, wr_last, swap_req,
    output coefficient, coef_valid, wr_ready, active_bank, load_err
  );

  modport master (
    output cnt, rd_en, wr_valid, wr_data, wr_last, swap_req,
    input  coefficient, coef_valid, wr_ready, active_bank, load_err
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: one registered coefficient per cycle from
// the active bank, shadow bank loaded over valid/ready and swapped at frame end.
module fir_coef_bank #(
  parameter int COEF_W    = 10,
  parameter int NTAPS     = 24,
  parameter int CNT_W     = 6,
  parameter int SYMMETRIC = 1
) (
  input  logic             clk,
  input  logic             rst,
  fir_coef_bank_if.slave   bus
);

  localparam int STORE_N = (SYMMETRIC != 0) ? (NTAPS + 1) / 2 : NTAPS;
  localparam int AW      = (STORE_N > 1) ? $clog2(STORE_N) : 1;

  // Range compares use one extra bit so NTAPS == 2**CNT_W does not wrap.
  localparam logic [CNT_W:0]   NTAPS_X    = (CNT_W + 1)'(NTAPS);
  localparam logic [CNT_W:0]   STORE_X    = (CNT_W + 1)'(STORE_N);
  localparam logic [CNT_W-1:0] LAST_TAP_C = CNT_W'(NTAPS - 1);
  localparam logic [AW-1:0]    PTR_LAST   = AW'(STORE_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PEND
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     ptr_q;
  logic              wr_ready_q;
  logic              load_err_q;
  logic              active_bank_q;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic              coef_valid_q, coef_valid_d;
  logic [COEF_W-1:0] bank_q [2][STORE_N];

  logic              rd_in_range;
  logic [CNT_W-1:0]  addr_full;
  logic [AW-1:0]     rd_addr;
  logic              wr_fire;
  logic              ptr_at_last;

  assign wr_fire     = bus.wr_valid & wr_ready_q;
  assign ptr_at_last = (ptr_q == PTR_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_in_range  = ({1'b0, bus.cnt} < NTAPS_X);
    addr_full    = bus.cnt;
    if ((SYMMETRIC != 0) && !({1'b0, bus.cnt} < STORE_X)) begin
      addr_full = LAST_TAP_C - bus.cnt;
    end
    rd_addr      = addr_full[AW-1:0];
    coef_d       = coef_q;
    coef_valid_d = 1'b0;
    if (bus.rd_en) begin
      if (rd_in_range) begin
        coef_d       = bank_q[active_bank_q][rd_addr];
        coef_valid_d = 1'b1;
      end else begin
        coef_d = '0;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q       <= '0;
      coef_valid_q <= 1'b0;
    end else begin
      coef_q       <= coef_d;
      coef_valid_q <= coef_valid_d;
    end
  end

  // NOTE: the banks carry a reset on purpose: a reset must leave both sets at
  // zero, which rules out plain RAM macros without a clear port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < STORE_N; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      bank_q[~active_bank_q][ptr_q] <= bus.wr_data;
    end
  end

  // Load / swap controller; wr_ready and load_err are registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      wr_ready_q    <= 1'b1;
      load_err_q    <= 1'b0;
      active_bank_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (wr_fire) begin
            if (bus.wr_last && ptr_at_last) begin
              state_q    <= ST_PEND;
              wr_ready_q <= 1'b0;
              ptr_q      <= '0;
            end else if (bus.wr_last || ptr_at_last) begin
              state_q    <= ST_IDLE;
              load_err_q <= 1'b1;
              ptr_q      <= '0;
            end else begin
              state_q <= ST_LOAD;
              ptr_q   <= ptr_q + 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (bus.swap_req) begin
            active_bank_q <= ~active_bank_q;
            state_q       <= ST_IDLE;
            wr_ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ptr_q      <= '0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.coefficient = coef_q;
  assign bus.coef_valid  = coef_valid_q;
  assign bus.wr_ready    = wr_ready_q;
  assign bus.active_bank = active_bank_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_fir_coef_bank.sv
// Randomised and directed bench for fir_coef_bank against a tap-list model of
// the two coefficient sets and the load/swap protocol.
module tb_fir_coef_bank;

  localparam int COEF_W  = 10;
  localparam int NTAPS   = 24;
  localparam int CNT_W   = 6;
  localparam int STORE_N = (NTAPS + 1) / 2;

  logic clk;
  logic rst;

  fir_coef_bank_if #(.COEF_W(COEF_W), .CNT_W(CNT_W)) bus ();

  fir_coef_bank #(
    .COEF_W(COEF_W), .NTAPS(NTAPS), .CNT_W(CNT_W), .SYMMETRIC(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: full tap lists for the live set and for a completed pending set.
  logic [COEF_W-1:0] m_taps [NTAPS];
  logic [COEF_W-1:0] m_pend [NTAPS];
  logic [COEF_W-1:0] m_words[$];
  bit                m_pend_v;
  bit                m_bank;
  logic [COEF_W-1:0] m_coef;
  bit                m_valid;
  bit                m_err;

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      m_taps[i] = '0;
      m_pend[i] = '0;
    end
    m_words.delete();
    m_pend_v = 0;
    m_bank   = 0;
    m_coef   = '0;
    m_valid  = 0;
    m_err    = 0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (bus.rd_en) begin
      if (int'(bus.cnt) < NTAPS) begin
        m_coef  = m_taps[bus.cnt];
        m_valid = 1;
      end else begin
        m_coef  = '0;
        m_valid = 0;
      end
    end else begin
      m_valid = 0;
    end
    if (!m_pend_v && bus.wr_valid) begin
      m_words.push_back(bus.wr_data);
      if (bus.wr_last && m_words.size() == STORE_N) begin
        for (int i = 0; i < STORE_N; i++) begin
          m_pend[i]           = m_words[i];
          m_pend[NTAPS-1-i]   = m_words[i];
        end
        m_pend_v = 1;
        m_words.delete();
      end else if (bus.wr_last || m_words.size() == STORE_N) begin
        m_err = 1;
        m_words.delete();
      end
    end else if (m_pend_v && bus.swap_req) begin
      m_taps   = m_pend;
      m_bank   = !m_bank;
      m_pend_v = 0;
    end
  endtask

  task automatic compare();
    check("coefficient", 32'(bus.coefficient), 32'(m_coef));
    check("coef_valid",  32'(bus.coef_valid),  32'(m_valid));
    check("wr_ready",    32'(bus.wr_ready),    32'(!m_pend_v));
    check("active_bank", 32'(bus.active_bank), 32'(m_bank));
    check("load_err",    32'(bus.load_err),    32'(m_err));
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    bus.rd_en    = 1'b0;
    bus.cnt      = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.swap_req = 1'b0;
  endtask

  task automatic drive_word(input int data, input bit last, input bit swap);
    bus.wr_valid = 1'b1;
    bus.wr_data  = COEF_W'(data);
    bus.wr_last  = last;
    bus.swap_req = swap;
    cycle();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.swap_req = 1'b0;
  endtask

  task automatic swap_pulse();
    bus.swap_req = 1'b1;
    cycle();
    bus.swap_req = 1'b0;
  endtask

  // Sweep all taps; each response is also compared with a fixed expectation.
  task automatic sweep(input string tag, input int exp_list[NTAPS]);
    for (int k = 0; k < NTAPS; k++) begin
      bus.rd_en = 1'b1;
      bus.cnt   = CNT_W'(k);
      cycle();
      check(tag, 32'($signed(bus.coefficient)), 32'(exp_list[k]));
    end
    bus.rd_en = 1'b0;
  endtask

  int first_set[STORE_N] = '{-1, -2, 4, 5, -8, -11, 15, 20, -29, -43, 75, 231};
  int exp_zero[NTAPS];
  int exp_sym [NTAPS]    = '{-1, -2, 4, 5, -8, -11, 15, 20, -29, -43, 75, 231,
                             231, 75, -43, -29, 20, 15, -11, -8, 5, 4, -2, -1};
  int exp_100 [NTAPS];

  initial begin
    for (int i = 0; i < NTAPS; i++) begin
      exp_zero[i] = 0;
      exp_100[i]  = 100;
    end
    model_reset();
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Cleared banks read as zero with one-cycle valid.
    sweep("reset_read", exp_zero);

    // First load, swap, mirrored readback.
    for (int i = 0; i < STORE_N; i++) drive_word(first_set[i], i == STORE_N - 1, 1'b0);
    cycle();
    swap_pulse();
    check("bank_after_swap1", 32'(bus.active_bank), 32'd1);
    sweep("sym_read", exp_sym);

    // Second load of 100s while reads run against the live set.
    bus.rd_en = 1'b1;
    for (int i = 0; i < STORE_N; i++) begin
      bus.cnt = CNT_W'($urandom_range(0, NTAPS - 1));
      drive_word(100, i == STORE_N - 1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      bus.cnt = CNT_W'($urandom_range(0, NTAPS - 1));
      cycle();
    end
    bus.cnt = 6'd0;
    swap_pulse();
    check("old_set_on_swap_edge", 32'($signed(bus.coefficient)), 32'(-1));
    sweep("all_100", exp_100);

    // Early wr_last on word 5, then a good load.
    for (int i = 0; i < 5; i++) drive_word($urandom_range(0, 1023), i == 4, 1'b0);
    check("early_last_err", 32'(bus.load_err), 32'd1);
    cycle();
    check("err_is_pulse", 32'(bus.load_err), 32'd0);
    for (int i = 0; i < STORE_N; i++) drive_word($urandom_range(0, 1023), i == STORE_N - 1, 1'b0);
    swap_pulse();
    check("bank_after_recovery", 32'(bus.active_bank), 32'd1);

    // Swap coinciding with the final word is ignored; a later one takes effect.
    for (int i = 0; i < STORE_N; i++) drive_word(first_set[i], i == STORE_N - 1, i == STORE_N - 1);
    check("no_swap_on_last", 32'(bus.active_bank), 32'd1);
    cycle();
    cycle();
    swap_pulse();
    check("late_swap", 32'(bus.active_bank), 32'd0);
    sweep("sym_read2", exp_sym);

    // Out-of-range read, then reset in the middle of a load.
    bus.rd_en = 1'b1;
    bus.cnt   = 6'd30;
    cycle();
    check("oor_valid", 32'(bus.coef_valid), 32'd0);
    bus.rd_en = 1'b0;
    for (int i = 0; i < 7; i++) drive_word($urandom_range(0, 1023), 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    bus.rd_en = 1'b1;
    bus.cnt   = 6'd11;
    cycle();
    check("read_after_reset", 32'(bus.coefficient), 32'd0);

    // Random traffic: mostly well-formed loads, occasional bad framing.
    for (int n = 0; n < 3000; n++) begin
      bus.rd_en    = ($urandom_range(0, 3) != 0);
      bus.cnt      = CNT_W'($urandom_range(0, 31));
      bus.wr_valid = $urandom_range(0, 1) != 0;
      bus.wr_data  = COEF_W'($urandom);
      bus.wr_last  = (m_words.size() == STORE_N - 1);
      if ($urandom_range(0, 15) == 0) bus.wr_last = !bus.wr_last;
      bus.swap_req = ($urandom_range(0, 7) == 0);
      cycle();
    end

    set_idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
